// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and 3-bit opcode encoding.
package alu_pkg;
    localparam int ALU_W = 8;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;
endpackage

// File: rtl/alu.sv
// Purely combinational 8-bit ALU; arithmetic wraps modulo 2^ALU_W, no flags.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [ALU_W-1:0] o_y
);
    always_comb begin
        o_y = '0;
        case (i_op)
            OP_PASS: o_y = i_a;
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_SHL:  o_y = {i_b[ALU_W-2:0], 1'b0};
            OP_SHR:  o_y = {1'b0, i_a[ALU_W-1:1]};
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, each with a
// one-deep registered response slot.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             busy
);
    logic             r_last;
    logic             r_v0, r_v1;
    logic [WIDTH-1:0] r_d0, r_d1;
    logic             w_elig0, w_elig1, w_gnt0, w_gnt1;
    logic [WIDTH-1:0] w_a, w_b, w_y;
    logic [2:0]       w_op;

    // A slot that drains this cycle can accept a new result at the same edge.
    assign w_elig0 = req0_valid && (!r_v0 || rsp0_ready);
    assign w_elig1 = req1_valid && (!r_v1 || rsp1_ready);
    // r_last = 1 means requester 1 won most recently, so a tie goes to 0.
    assign w_gnt0  = rst_n && w_elig0 && (!w_elig1 || r_last);
    assign w_gnt1  = rst_n && w_elig1 && (!w_elig0 || !r_last);

    assign w_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_b  = w_gnt1 ? req1_b  : req0_b;
    assign w_op = w_gnt1 ? req1_op : req0_op;

    alu u_alu (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_op (w_op),
        .o_y  (w_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_d0   <= '0;
            r_d1   <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) r_last <= w_gnt1;
            if (w_gnt0) begin
                r_v0 <= 1'b1;
                r_d0 <= w_y;
            end else if (rsp0_ready) begin
                r_v0 <= 1'b0;
            end
            if (w_gnt1) begin
                r_v1 <= 1'b1;
                r_d1 <= w_y;
            end else if (rsp1_ready) begin
                r_v1 <= 1'b0;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = r_v0;
    assign rsp1_valid = r_v1;
    assign rsp0_data  = r_d0;
    assign rsp1_data  = r_d1;
    assign busy       = r_v0 || r_v1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a small reference model predicts grants,
// queues expected results at acceptance and compares them at the response edge.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, busy;
    logic [7:0] rsp0_data, rsp1_data;

    int n_chk = 0;
    int n_fail = 0;

    logic       m_last, m_v0, m_v1;
    logic [7:0] m_d0, m_d1;
    logic [7:0] q0[$], q1[$];
    logic       obs_rdy0, obs_rdy1;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0: return a;
            3'd1: return 8'((a + b) & 9'h0FF);
            3'd2: return 8'((9'h100 + a - b) & 9'h0FF);
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return {b[6:0], 1'b0};
            default: return {1'b0, a[7:1]};
        endcase
    endfunction

    task automatic check_slots(input string tag);
        check({tag, "_v0"}, rsp0_valid, m_v0);
        check({tag, "_v1"}, rsp1_valid, m_v1);
        check({tag, "_d0"}, rsp0_data, m_d0);
        check({tag, "_d1"}, rsp1_data, m_d1);
        check({tag, "_busy"}, busy, m_v0 || m_v1);
    endtask

    // One clock: predict and check grants mid-cycle, then check slots after the edge.
    task automatic step(input string tag);
        logic e0, e1, g0, g1;
        @(negedge clk);
        e0 = req0_valid && (!m_v0 || rsp0_ready);
        e1 = req1_valid && (!m_v1 || rsp1_ready);
        g0 = e0 && (!e1 || m_last);
        g1 = e1 && (!e0 || !m_last);
        obs_rdy0 = req0_ready;
        obs_rdy1 = req1_ready;
        check({tag, "_rdy0"}, req0_ready, g0);
        check({tag, "_rdy1"}, req1_ready, g1);
        if (g0) q0.push_back(ref_alu(req0_a, req0_b, req0_op));
        if (g1) q1.push_back(ref_alu(req1_a, req1_b, req1_op));
        @(posedge clk);
        #1;
        if (g0 || g1) m_last = g1;
        if (g0) begin m_v0 = 1'b1; m_d0 = q0.pop_front(); end
        else if (rsp0_ready) m_v0 = 1'b0;
        if (g1) begin m_v1 = 1'b1; m_d1 = q1.pop_front(); end
        else if (rsp1_ready) m_v1 = 1'b0;
        check_slots(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_rdy0"}, req0_ready, 1'b0);
        check({tag, "_rdy1"}, req1_ready, 1'b0);
        @(posedge clk);
        #1;
        m_last = 1'b1; m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = 8'h00; m_d1 = 8'h00;
        q0.delete(); q1.delete();
        check_slots(tag);
        check({tag, "_busy0"}, busy, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        @(posedge clk);
        #1;
        do_reset("rst");

        // Single request, latency and busy
        req0_valid = 1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 3'b001;
        step("t1");
        check("t1_rdy_obs", obs_rdy0, 1'b1);
        check("t1_data", rsp0_data, 8'h08);
        check("t1_busy", busy, 1'b1);
        req0_valid = 0; rsp0_ready = 1;
        step("t1_drain");

        // Tie right after reset goes to requester 0, then alternates
        do_reset("t2_rst");
        req0_valid = 1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 3'b010;
        req1_valid = 1; req1_a = 8'hF0; req1_b = 8'hFF; req1_op = 3'b101;
        rsp0_ready = 1; rsp1_ready = 1;
        step("t2_a");
        check("t2_first0", obs_rdy0, 1'b1);
        check("t2_d0", rsp0_data, 8'h0F);
        step("t2_b");
        check("t2_second1", obs_rdy1, 1'b1);
        check("t2_d1", rsp1_data, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            req0_a = 8'($urandom_range(0, 255)); req0_op = 3'($urandom_range(0, 7));
            req1_b = 8'($urandom_range(0, 255)); req1_op = 3'($urandom_range(0, 7));
            step("t2_alt");
            check("t2_alt_turn", obs_rdy0, (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Back-pressure on slot 1: requester 0 wins every cycle
        rsp1_ready = 0;
        for (int i = 0; i < 4; i++) begin
            req0_b = 8'($urandom_range(0, 255));
            step("t3_bp");
            check("t3_rdy1_low", obs_rdy1, 1'b0);
        end
        rsp1_ready = 1;
        step("t3_release");
        check("t3_rdy1_back", obs_rdy1, 1'b1);

        // Back-to-back on requester 0 with its slot full and draining
        req1_valid = 0;
        req0_a = 8'h00; req0_b = 8'h81; req0_op = 3'b110;
        step("t4_shl");
        check("t4_shl_d", rsp0_data, 8'h02);
        req0_a = 8'h81; req0_b = 8'h00; req0_op = 3'b111;
        step("t4_shr");
        check("t4_shr_d", rsp0_data, 8'h40);
        check("t4_v", rsp0_valid, 1'b1);

        // Wraparound
        req0_a = 8'hFF; req0_b = 8'h02; req0_op = 3'b001;
        step("t5_add");
        check("t5_add_d", rsp0_data, 8'h01);
        req0_a = 8'h00; req0_b = 8'h01; req0_op = 3'b010;
        step("t5_sub");
        check("t5_sub_d", rsp0_data, 8'hFF);

        // Reset while slot 0 is full and requester 1 would be granted
        req0_valid = 0; rsp0_ready = 0;
        req1_valid = 1; req1_a = 8'h33; req1_b = 8'h11; req1_op = 3'b001;
        do_reset("t6_rst");
        req0_valid = 1; req0_a = 8'h07; req0_op = 3'b000;
        rsp0_ready = 1; rsp1_ready = 1;
        step("t6_tie");
        check("t6_tie0", obs_rdy0, 1'b1);
        check("t6_tie_d", rsp0_data, 8'h07);

        req0_valid = 0; req1_valid = 0;
        step("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit combinational `alu` between two requesters, e.g. the instruction sequencer and an auxiliary engine. Each requester has a valid/ready request channel carrying operands and opcode, and a one-deep registered response slot. Requests are arbitrated round-robin, and one ALU operation is accepted per cycle. Each result appears in the requester's response slot one cycle after acceptance.

## Interface
- `WIDTH`, default 8: operand/result width. Only 8 is supported because it must match `alu`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_a` in WIDTH: operand A.
- `req0_b` in WIDTH: operand B.
- `req0_op` in 3: ALU select (encoding in `alu_pkg`).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as above, for requester 1.
- `rsp0_valid` out 1: requester 0's response slot holds a result.
- `rsp0_ready` in 1: requester 0 consumes its result this cycle.
- `rsp0_data` out WIDTH: result.
- `rsp1_valid`, `rsp1_ready`, `rsp1_data`: same as above, for requester 1.
- `busy` out 1: any response slot is full.

## Operation
- **Handshakes.**
  - Request accepted when `reqN_valid && reqN_ready`.
  - Response consumed when `rspN_valid && rspN_ready`.
  - The block samples operands only on acceptance. A requester must hold `valid`, `a`, `b` and `op` stable until `ready`.
- **Eligibility.** Requester N is eligible when `reqN_valid && (!rspN_valid || rspN_ready)`: its slot is empty or drains this cycle.
- **Arbitration.**
  - Round-robin pointer `last` (1 bit) records the most recently granted requester.
  - Both eligible: grant goes to `!last`.
  - One eligible: that one is granted, regardless of `last`.
  - None eligible: no grant.
  - `last` updates only on a grant.
- **Ready.** `reqN_ready` = grant to N. It is combinational from the valids, `rspN_valid` and `rspN_ready`. At most one `ready` is high per cycle.
- **ALU path.** A mux selects the granted requester's a/b/op into the single `alu` instance. The result is written into the granted slot at the next edge.
- **Opcode encoding:**
  - 000: PASS A
  - 001: A+B
  - 010: A−B
  - 011: AND
  - 100: OR
  - 101: XOR
  - 110: B<<1
  - 111: A>>1
- **Arithmetic.** All arithmetic is modulo 2^8 and wraps silently; there is no carry or flag.
- **Slot update, per slot per edge:**
  - Grant: `valid`←1, `data`←ALU result. This also covers a simultaneous drain and grant, where valid stays 1 and data is replaced.
  - Drain without grant: `valid`←0. `data` holds its last value.
  - Neither: hold.
- **`busy`** = `rsp0_valid || rsp1_valid`, registered-derived.

## Timing
- **Reset** (`rst_n`=0 at an edge):
  - `rsp0_valid`=`rsp1_valid`=0, `rsp0_data`=`rsp1_data`=0x00, `busy`=0, `last`=1 (so requester 0 wins the first tie).
  - `req*_ready` is forced 0 while `rst_n`=0.
  - Reset mid-operation discards slot contents and any same-cycle grant.
- **Latency.** Accept at edge n; `rspN_valid`=1 with the result after edge n.
- **Throughput.**
  - One accepted operation per cycle total.
  - A single requester with `rsp_ready` held high sustains one op per cycle.
  - With both requesters saturating, each gets every other cycle.
- **Back-pressure.** With `rspN_ready`=0 and `rspN_valid`=1, `reqN_ready` stays 0 indefinitely. The other requester is unaffected and may win every cycle.
- **No combinational path** from `req*_a/b/op` to any output.

## Structure
- **Shared package `alu_pkg`:**
  - `ALU_W`=8.
  - 3-bit opcode localparams `OP_PASS`, `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_XOR`, `OP_SHL`, `OP_SHR`.
  - Both `alu` and this block use it.
- **Sub-module.** One instance of the existing `alu` is the only sub-module. Arbitration, the operand mux and the slots stay in this module; there is no separate FSM beyond the `last` bit and two slot-valid bits.

## Test plan
1. Reset, then `req0` a=0x05 b=0x03 op=001 → `req0_ready`=1 the same cycle; next cycle `rsp0_valid`=1, `rsp0_data`=0x08, `busy`=1.
2. Both valid on the first cycle after reset: `req0` 010 with 0x10,0x01 and `req1` 101 with 0xF0,0xFF, both rsp_ready=1.
   - Expect `req0` granted at cycle n and `req1` at n+1.
   - `rsp0_data`=0x0F after n and `rsp1_data`=0x0F after n+1.
   - Repeated requests alternate 0,1,0,1.
3. `rsp1_ready`=0 with `rsp1` full and both requesting → `req1_ready` stays 0; `req0` is granted every cycle. Raising `rsp1_ready` gives `req1` the next grant.
4. Back-to-back on the same requester with `rsp0_ready`=1 and `rsp0_valid`=1: op 110 b=0x81 → `rsp0_valid` stays 1 and `rsp0_data` becomes 0x02 the next cycle; then op 111 a=0x81 → 0x40.
5. Wrap checks: op 001 with 0xFF,0x02 → 0x01; op 010 with 0x00,0x01 → 0xFF.
6. `rst_n`=0 for one edge while `rsp0_valid`=1 and `req1` is being granted → after the edge all rsp valids and data are 0, `busy`=0, and the next tie goes to `req0`.
